// File: rtl/uart_ctrl.sv
// uart_ctrl: full-duplex UART, runtime divisor and parity mode,
// RX/TX FIFOs, sticky frame/parity/overrun flags.

module uart_fifo #(
  parameter int W  = 8,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic         rd,
  input  logic [W-1:0] w_data,
  output logic [W-1:0] r_data,
  output logic         empty,
  output logic         full
);
  localparam int DEPTH = 2 ** AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          wr_en;
  logic          rd_en;

  assign empty  = (cnt == '0);
  assign full   = (cnt == (AW+1)'(DEPTH));
  assign rd_en  = rd & ~empty;
  // a write on full only lands when a read frees the slot
  assign wr_en  = wr & (~full | rd_en);
  assign r_data = empty ? '0 : mem[rp];

  always_ff @(posedge clk)
    if (wr_en) mem[wp] <= w_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr_en) wp <= wp + 1'b1;
      if (rd_en) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(wr_en)
                 - (AW+1)'(rd_en);
    end
  end
endmodule

module uart_ctrl #(
  parameter int DBIT     = 8,
  parameter int SB_TICK  = 16,
  parameter int DVSR_BIT = 11,
  parameter int FIFO_W   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DVSR_BIT-1:0] dvsr,
  input  logic [1:0]          parity_mode,
  input  logic                rx,
  output logic                tx,
  input  logic                wr_uart,
  input  logic [DBIT-1:0]     w_data,
  output logic                tx_full,
  input  logic                rd_uart,
  output logic [DBIT-1:0]     r_data,
  output logic                rx_empty,
  input  logic                clr_err,
  output logic                frame_err,
  output logic                parity_err,
  output logic                overrun_err
);
  localparam int NW = $clog2(DBIT);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT-1);
  localparam logic [5:0] T_MID  = 6'd7;
  localparam logic [5:0] T_END  = 6'd15;
  localparam logic [5:0] T_STOP = 6'(SB_TICK-1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [DVSR_BIT-1:0] bcnt;
  logic                tick;

  assign tick = (bcnt == dvsr);

  always_ff @(posedge clk) begin
    if (reset)     bcnt <= '0;
    else if (tick) bcnt <= '0;
    else           bcnt <= bcnt + 1'b1;
  end

  logic            par_en;
  logic            par_odd;

  assign par_en  = ^parity_mode;
  assign par_odd = (parity_mode == 2'b10);

  // receiver
  logic [2:0]      rx_st;
  logic [5:0]      rx_s;
  logic [NW-1:0]   rx_n;
  logic [DBIT-1:0] rx_b;
  logic            rx_pen;
  logic            rx_odd;
  logic            rx_stop_done;
  logic            rx_par_done;
  logic            rx_full;

  assign rx_stop_done = (rx_st == S_STOP) & tick
                      & (rx_s == T_STOP);
  assign rx_par_done  = (rx_st == S_PAR) & tick
                      & (rx_s == T_END);

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_st  <= S_IDLE;
      rx_s   <= '0;
      rx_n   <= '0;
      rx_b   <= '0;
      rx_pen <= 1'b0;
      rx_odd <= 1'b0;
    end else begin
      unique case (rx_st)
        S_IDLE:
          if (!rx) begin
            rx_st  <= S_START;
            rx_s   <= '0;
            rx_pen <= par_en;
            rx_odd <= par_odd;
          end
        S_START:
          if (tick) begin
            if (rx_s == T_MID) begin
              rx_s <= '0;
              rx_n <= '0;
              rx_st <= rx ? S_IDLE : S_DATA;
            end else begin
              rx_s <= rx_s + 1'b1;
            end
          end
        S_DATA:
          if (tick) begin
            if (rx_s == T_END) begin
              rx_s <= '0;
              rx_b <= {rx, rx_b[DBIT-1:1]};
              if (rx_n == N_LAST)
                rx_st <= rx_pen ? S_PAR : S_STOP;
              else
                rx_n <= rx_n + 1'b1;
            end else begin
              rx_s <= rx_s + 1'b1;
            end
          end
        S_PAR:
          if (tick) begin
            if (rx_s == T_END) begin
              rx_s  <= '0;
              rx_st <= S_STOP;
            end else begin
              rx_s <= rx_s + 1'b1;
            end
          end
        S_STOP:
          if (tick) begin
            if (rx_s == T_STOP) rx_st <= S_IDLE;
            else                rx_s  <= rx_s + 1'b1;
          end
        default: rx_st <= S_IDLE;
      endcase
    end
  end

  uart_fifo #(.W(DBIT), .AW(FIFO_W)) u_rx_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr     (rx_stop_done),
    .rd     (rd_uart),
    .w_data (rx_b),
    .r_data (r_data),
    .empty  (rx_empty),
    .full   (rx_full)
  );

  logic fe_set;
  logic pe_set;
  logic ov_set;

  assign fe_set = rx_stop_done & ~rx;
  assign pe_set = rx_par_done
                & (rx != (^rx_b ^ rx_odd));
  assign ov_set = rx_stop_done & rx_full;

  // a new event wins over a simultaneous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= fe_set | (frame_err & ~clr_err);
      parity_err  <= pe_set | (parity_err & ~clr_err);
      overrun_err <= ov_set | (overrun_err & ~clr_err);
    end
  end

  // transmitter
  logic [2:0]      tx_st;
  logic [5:0]      tx_s;
  logic [NW-1:0]   tx_n;
  logic [DBIT-1:0] tx_b;
  logic            tx_pen;
  logic            tx_pbit;
  logic            tx_next;
  logic            tx_pop;
  logic            tx_empty;
  logic [DBIT-1:0] tx_head;

  assign tx_pop = (tx_st == S_IDLE) & ~tx_empty;

  uart_fifo #(.W(DBIT), .AW(FIFO_W)) u_tx_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr     (wr_uart),
    .rd     (tx_pop),
    .w_data (w_data),
    .r_data (tx_head),
    .empty  (tx_empty),
    .full   (tx_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_st   <= S_IDLE;
      tx_s    <= '0;
      tx_n    <= '0;
      tx_b    <= '0;
      tx_pen  <= 1'b0;
      tx_pbit <= 1'b0;
    end else begin
      unique case (tx_st)
        S_IDLE:
          if (tx_pop) begin
            tx_st   <= S_START;
            tx_s    <= '0;
            tx_b    <= tx_head;
            tx_pen  <= par_en;
            tx_pbit <= ^tx_head ^ par_odd;
          end
        S_START:
          if (tick) begin
            if (tx_s == T_END) begin
              tx_s  <= '0;
              tx_n  <= '0;
              tx_st <= S_DATA;
            end else begin
              tx_s <= tx_s + 1'b1;
            end
          end
        S_DATA:
          if (tick) begin
            if (tx_s == T_END) begin
              tx_s <= '0;
              tx_b <= tx_b >> 1;
              if (tx_n == N_LAST)
                tx_st <= tx_pen ? S_PAR : S_STOP;
              else
                tx_n <= tx_n + 1'b1;
            end else begin
              tx_s <= tx_s + 1'b1;
            end
          end
        S_PAR:
          if (tick) begin
            if (tx_s == T_END) begin
              tx_s  <= '0;
              tx_st <= S_STOP;
            end else begin
              tx_s <= tx_s + 1'b1;
            end
          end
        S_STOP:
          if (tick) begin
            if (tx_s == T_STOP) tx_st <= S_IDLE;
            else                tx_s  <= tx_s + 1'b1;
          end
        default: tx_st <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    tx_next = 1'b1;
    unique case (tx_st)
      S_START: tx_next = 1'b0;
      S_DATA:  tx_next = tx_b[0];
      S_PAR:   tx_next = tx_pbit;
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) tx <= 1'b1;
    else       tx <= tx_next;
  end
endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl: directed bench for uart_ctrl with a
// frame-level RX FIFO / error-flag model checked every cycle.

module tb_uart_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] dvsr;
  logic [1:0]  parity_mode;
  logic        rx;
  logic        tx;
  logic        wr_uart;
  logic [7:0]  w_data;
  logic        tx_full;
  logic        rd_uart;
  logic [7:0]  r_data;
  logic        rx_empty;
  logic        clr_err;
  logic        frame_err;
  logic        parity_err;
  logic        overrun_err;

  logic        rx_drv;
  logic        lb;
  logic        mon_en;
  int          cyc;
  int          nchk;
  int          nfail;

  logic [7:0]  mq[$];
  int          m_fe;
  int          m_pe;
  int          m_ov;

  assign rx = lb ? tx : rx_drv;

  uart_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .dvsr        (dvsr),
    .parity_mode (parity_mode),
    .rx          (rx),
    .tx          (tx),
    .wr_uart     (wr_uart),
    .w_data      (w_data),
    .tx_full     (tx_full),
    .rd_uart     (rd_uart),
    .r_data      (r_data),
    .rx_empty    (rx_empty),
    .clr_err     (clr_err),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .overrun_err (overrun_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    cyc <= reset ? 0 : cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  // 2 = frame in flight, flag may be either value
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (mq.size() == 0)
        chk("rx_empty_model", 32'(rx_empty), 1);
      if (rx_empty)
        chk("r_data_empty", 32'(r_data), 0);
      else if (mq.size() > 0)
        chk("rx_head_model", 32'(r_data),
            32'(mq[0]));
      if (m_fe != 2)
        chk("frame_err_model", 32'(frame_err),
            32'(m_fe));
      if (m_pe != 2)
        chk("parity_err_model", 32'(parity_err),
            32'(m_pe));
      if (m_ov != 2)
        chk("overrun_err_model", 32'(overrun_err),
            32'(m_ov));
    end
  end

  task automatic drive(input logic v, input int n);
    rx_drv = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] d,
                         input logic [1:0] pm,
                         input logic pbit,
                         input bit stop0);
    bit par;
    bit pe;
    bit drop;
    par  = (pm == 2'b01) || (pm == 2'b10);
    pe   = par && (pbit != (^d ^ (pm == 2'b10)));
    drop = (mq.size() >= 4);
    if (drop) m_ov = 2;
    else      mq.push_back(d);
    if (stop0) m_fe = 2;
    if (pe)    m_pe = 2;
    drive(1'b0, 64);
    for (int k = 0; k < 8; k++) drive(d[k], 64);
    if (par)   drive(pbit, 64);
    if (stop0) drive(1'b0, 44);
    drive(1'b1, 120);
    if (drop)  m_ov = 1;
    if (stop0) m_fe = 1;
    if (pe)    m_pe = 1;
  endtask

  task automatic wr_byte(input logic [7:0] d);
    @(negedge clk);
    wr_uart = 1'b1;
    w_data  = d;
    if (lb) mq.push_back(d);
    @(negedge clk);
    wr_uart = 1'b0;
  endtask

  task automatic rd_byte(input string nm,
                         input logic [7:0] exp);
    @(negedge clk);
    chk(nm, 32'(r_data), 32'(exp));
    chk("rd_not_empty", 32'(rx_empty), 0);
    rd_uart = 1'b1;
    if (mq.size() > 0) void'(mq.pop_front());
    @(negedge clk);
    rd_uart = 1'b0;
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr_err = 1'b1;
    m_fe = 0;
    m_pe = 0;
    m_ov = 0;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  // samples each bit mid-way, from the start-bit fall
  task automatic decode_tx(input bit par,
                           output logic [7:0] d,
                           output logic p,
                           output logic s);
    int n;
    n = 0;
    d = '0;
    p = 1'b0;
    s = 1'b0;
    while (tx !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("tx_frame_start", 32'(tx), 0);
    if (tx === 1'b0) begin
      repeat (30) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        repeat (64) @(negedge clk);
        d[k] = tx;
      end
      if (par) begin
        repeat (64) @(negedge clk);
        p = tx;
      end
      repeat (64) @(negedge clk);
      s = tx;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a5;
    logic [7:0] lbd [3];
    logic       lbp [3];
    logic [7:0] ovd [5];
    logic [7:0] d;
    logic       p;
    logic       s;
    int         w;
    int         rel;
    int         errs;
    int         zc;
    int         n;
    logic       ev;

    nchk = 0;
    nfail = 0;
    reset = 1'b1;
    dvsr = 11'd3;
    parity_mode = 2'b00;
    rx_drv = 1'b1;
    lb = 1'b0;
    mon_en = 1'b0;
    wr_uart = 1'b0;
    w_data = '0;
    rd_uart = 1'b0;
    clr_err = 1'b0;
    m_fe = 0;
    m_pe = 0;
    m_ov = 0;
    a5 = 8'hA5;
    lbd = '{8'h00, 8'hFF, 8'h07};
    lbp = '{1'b0, 1'b0, 1'b1};
    ovd = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", 32'(tx), 1);
    chk("rst_tx_full", 32'(tx_full), 0);
    chk("rst_rx_empty", 32'(rx_empty), 1);
    chk("rst_r_data", 32'(r_data), 0);
    chk("rst_errs", 32'({frame_err, parity_err,
                         overrun_err}), 0);
    reset = 1'b0;
    mon_en = 1'b1;

    // 0xA5, pop aligned just after a baud tick
    while (cyc % 4 != 2) @(negedge clk);
    wr_uart = 1'b1;
    w_data = 8'hA5;
    @(negedge clk);
    wr_uart = 1'b0;
    w = cyc;
    errs = 0;
    zc = 0;
    for (int i = 0; i < 662; i++) begin
      @(negedge clk);
      rel = cyc - (w + 2);
      if (rel < 0)        ev = 1'b1;
      else if (rel < 64)  ev = 1'b0;
      else if (rel < 576) ev = a5[(rel - 64) / 64];
      else                ev = 1'b1;
      if (tx !== ev) errs++;
      if (tx === 1'b0) zc++;
    end
    chk("tx_a5_wave", 32'(errs), 0);
    chk("tx_a5_low_cycles", 32'(zc), 320);

    // loopback with even parity
    parity_mode = 2'b01;
    lb = 1'b1;
    fork
      begin
        for (int i = 0; i < 3; i++) wr_byte(lbd[i]);
      end
      begin
        for (int i = 0; i < 3; i++) begin
          decode_tx(1'b1, d, p, s);
          chk("lb_tx_data", 32'(d), 32'(lbd[i]));
          chk("lb_tx_parity", 32'(p), 32'(lbp[i]));
          chk("lb_tx_stop", 32'(s), 1);
        end
      end
    join
    repeat (100) @(negedge clk);
    lb = 1'b0;
    rd_byte("lb_rd0", 8'h00);
    rd_byte("lb_rd1", 8'hFF);
    rd_byte("lb_rd2", 8'h07);
    chk("lb_parity_err", 32'(parity_err), 0);

    // start glitch: low for 3 ticks
    parity_mode = 2'b00;
    drive(1'b0, 12);
    drive(1'b1, 200);
    chk("glitch_empty", 32'(rx_empty), 1);
    chk("glitch_errs", 32'({frame_err, parity_err,
                            overrun_err}), 0);

    // stop bit held low
    send_rx(8'h55, 2'b00, 1'b0, 1'b1);
    chk("stop0_frame_err", 32'(frame_err), 1);
    repeat (50) @(negedge clk);
    chk("stop0_sticky", 32'(frame_err), 1);
    rd_byte("stop0_rd", 8'h55);
    do_clr();
    chk("clr_frame_err", 32'(frame_err), 0);

    // odd parity: good frame, then bad parity bit
    parity_mode = 2'b10;
    send_rx(8'h01, 2'b10, 1'b0, 1'b0);
    chk("odd_ok_perr", 32'(parity_err), 0);
    send_rx(8'h03, 2'b10, 1'b0, 1'b0);
    chk("odd_bad_perr", 32'(parity_err), 1);
    rd_byte("odd_rd0", 8'h01);
    rd_byte("odd_rd1", 8'h03);
    do_clr();
    chk("clr_parity_err", 32'(parity_err), 0);

    // overrun: 5 frames into a 4-deep FIFO
    parity_mode = 2'b00;
    for (int i = 0; i < 5; i++)
      send_rx(ovd[i], 2'b00, 1'b0, 1'b0);
    chk("ovr_flag", 32'(overrun_err), 1);
    for (int i = 0; i < 4; i++)
      rd_byte("ovr_rd", ovd[i]);
    @(negedge clk);
    chk("ovr_drained", 32'(rx_empty), 1);
    do_clr();
    chk("clr_overrun_err", 32'(overrun_err), 0);

    // fill TX FIFO, then reset mid data bit 3
    @(negedge clk);
    wr_uart = 1'b1;
    w_data = 8'h34;
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      w_data = 8'(i);
    end
    @(negedge clk);
    wr_uart = 1'b0;
    chk("tx_full_set", 32'(tx_full), 1);
    n = 0;
    while (tx !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("rst_frame_start", 32'(tx), 0);
    repeat (64 * 4 + 30) @(negedge clk);
    chk("pre_rst_bit3", 32'(tx), 0);
    reset = 1'b1;
    mq.delete();
    m_fe = 0;
    m_pe = 0;
    m_ov = 0;
    @(negedge clk);
    chk("mid_rst_tx", 32'(tx), 1);
    chk("mid_rst_tx_full", 32'(tx_full), 0);
    chk("mid_rst_rx_empty", 32'(rx_empty), 1);
    reset = 1'b0;
    zc = 0;
    repeat (800) begin
      @(negedge clk);
      if (tx !== 1'b1) zc++;
    end
    chk("post_rst_tx_idle", 32'(zc), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end
endmodule
